csr_unit: RTL and testbench

Machine-mode CSR file and trap controller for the single-cycle RV32I core. Executes CSRRW/CSRRS/CSRRC and their immediate forms, and owns the trap state: mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch, mcycle and minstret. It sits beside the write-back path. It consumes the decoder's exception flags and the interrupt pins, and drives the trap/return redirect into the fetch PC mux and the CSR read data into write-back.

---
 rtl/csr_pkg.sv | 46 ++++
 rtl/csr_unit_if.sv | 43 ++++
 rtl/csr_counter64.sv | 40 ++++
 rtl/csr_unit.sv | 202 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, trap cause codes,
// writable-bit masks and the CSR operation encoding.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  localparam logic [31:0] CAUSE_M_EXT_INT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_M_SW_INT     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_M_TIMER_INT  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;

  localparam int unsigned IRQ_SW_BIT    = 3;
  localparam int unsigned IRQ_TIMER_BIT = 7;
  localparam int unsigned IRQ_EXT_BIT   = 11;

  localparam logic [31:0] MIE_WRITE_MASK   = 32'h0000_0888;
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;
  localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_unit_if.sv
// Decoder/datapath-facing bus of the CSR unit. The master side is the core
// (decode, register file, fetch mux); the slave side is csr_unit.
interface csr_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_en_in;
  logic [1:0]      csr_op_in;
  logic            csr_imm_in;
  logic [11:0]     csr_addr_in;
  logic [4:0]      src_field_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] pc_in;
  logic            instr_retire_in;
  logic            illegal_ins_in;
  logic            ecall_in;
  logic            ebreak_in;
  logic            mret_in;
  logic            external_int_in;
  logic            software_int_in;
  logic            timer_int_in;
  logic [XLEN-1:0] csr_data_out;
  logic            illegal_csr_out;
  logic            trap_true_out;
  logic [XLEN-1:0] trap_address_out;
  logic            return_trap_out;
  logic [XLEN-1:0] return_address_out;

  modport master (
    output csr_en_in, csr_op_in, csr_imm_in, csr_addr_in, src_field_in, rs1_data_in,
           pc_in, instr_retire_in, illegal_ins_in, ecall_in, ebreak_in, mret_in,
           external_int_in, software_int_in, timer_int_in,
    input  csr_data_out, illegal_csr_out, trap_true_out, trap_address_out,
           return_trap_out, return_address_out
  );

  modport slave (
    input  csr_en_in, csr_op_in, csr_imm_in, csr_addr_in, src_field_in, rs1_data_in,
           pc_in, instr_retire_in, illegal_ins_in, ecall_in, ebreak_in, mret_in,
           external_int_in, software_int_in, timer_int_in,
    output csr_data_out, illegal_csr_out, trap_true_out, trap_address_out,
           return_trap_out, return_address_out
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half software write; a write to either half
// replaces that cycle's increment for the whole counter.
module csr_counter64 #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              inc_en_in,
  input  logic              wr_lo_in,
  input  logic              wr_hi_in,
  input  logic [XLEN-1:0]   wr_data_in,
  output logic [2*XLEN-1:0] count_out
);

  logic [2*XLEN-1:0] count_q, count_d;

  // NOTE: the default assignment comes first so no path through the block infers a latch.
  always_comb begin
    count_d = count_q;
    if (wr_lo_in) begin
      count_d[XLEN-1:0] = wr_data_in;
    end else if (wr_hi_in) begin
      count_d[2*XLEN-1:XLEN] = wr_data_in;
    end else if (inc_en_in) begin
      count_d = count_q + (2*XLEN)'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the single-cycle RV32I core.
// Reads and redirects are combinational; writes, trap entry and mret commit on the edge.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input logic       clk_in,
  input logic       reset_in,
  csr_unit_if.slave bus
);

  csr_op_e           op;
  logic [XLEN-1:0]   src, old_val, new_val, mstatus_rd, mip, irq;
  logic              addr_valid, illegal_csr, csr_we;
  logic              int_pend, trap_any, trap_true, return_trap;
  logic [XLEN-1:0]   trap_cause, trap_base, trap_address;

  logic              mstatus_mie_q, mstatus_mie_d;
  logic              mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0]   mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0]   mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

  logic [2*XLEN-1:0] mcycle, minstret;
  logic              mcycle_wr_lo, mcycle_wr_hi, minstret_wr_lo, minstret_wr_hi, minstret_inc;

  assign op  = csr_op_e'(bus.csr_op_in);
  assign src = bus.csr_imm_in ? XLEN'(bus.src_field_in) : bus.rs1_data_in;

  always_comb begin
    mstatus_rd                   = '0;
    mstatus_rd[12:11]            = MSTATUS_MPP_M;
    mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
    mip                          = '0;
    mip[IRQ_EXT_BIT]             = bus.external_int_in;
    mip[IRQ_TIMER_BIT]           = bus.timer_int_in;
    mip[IRQ_SW_BIT]              = bus.software_int_in;
  end

  always_comb begin
    old_val    = '0;
    addr_valid = 1'b1;
    case (bus.csr_addr_in)
      CSR_MSTATUS:   old_val = mstatus_rd;
      CSR_MISA:      old_val = MISA_VALUE;
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MIP:       old_val = mip;
      CSR_MCYCLE:    old_val = mcycle[XLEN-1:0];
      CSR_MCYCLEH:   old_val = mcycle[2*XLEN-1:XLEN];
      CSR_MINSTRET:  old_val = minstret[XLEN-1:0];
      CSR_MINSTRETH: old_val = minstret[2*XLEN-1:XLEN];
      CSR_MHARTID:   old_val = '0;
      default:       addr_valid = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = src;
      CSR_OP_RS: new_val = old_val | src;
      CSR_OP_RC: new_val = old_val & ~src;
      default:   new_val = old_val;
    endcase
  end

  assign illegal_csr = bus.csr_en_in & ~addr_valid;

  // Set/clear with a zero source field is a pure read and must not disturb side effects.
  assign csr_we = bus.csr_en_in & addr_valid & (op != CSR_OP_NONE) &
                  ((op == CSR_OP_RW) | (bus.src_field_in != '0)) & ~trap_true;

  assign irq      = mie_q & mip;
  assign int_pend = mstatus_mie_q & (|irq);

  always_comb begin
    trap_any   = 1'b1;
    trap_cause = '0;
    if (int_pend) begin
      if (irq[IRQ_EXT_BIT])     trap_cause = CAUSE_M_EXT_INT;
      else if (irq[IRQ_SW_BIT]) trap_cause = CAUSE_M_SW_INT;
      else                      trap_cause = CAUSE_M_TIMER_INT;
    end else if (bus.illegal_ins_in | illegal_csr) begin
      trap_cause = CAUSE_ILLEGAL_INSN;
    end else if (bus.ebreak_in) begin
      trap_cause = CAUSE_BREAKPOINT;
    end else if (bus.ecall_in) begin
      trap_cause = CAUSE_ECALL_M;
    end else begin
      trap_any = 1'b0;
    end
  end

  assign trap_true   = trap_any & ~reset_in;
  assign return_trap = bus.mret_in & ~trap_true & ~reset_in;

  // Only interrupts are vectored; the cause MSB distinguishes them from exceptions.
  assign trap_base    = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_address = ((mtvec_q[1:0] == MTVEC_MODE_VECTORED) && trap_cause[XLEN-1])
                      ? trap_base + XLEN'({trap_cause[3:0], 2'b00})
                      : trap_base;

  assign bus.csr_data_out       = old_val;
  assign bus.illegal_csr_out    = illegal_csr;
  assign bus.trap_true_out      = trap_true;
  assign bus.trap_address_out   = trap_address;
  assign bus.return_trap_out    = return_trap;
  assign bus.return_address_out = mepc_q;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (csr_we) begin
      case (bus.csr_addr_in)
        CSR_MSTATUS: begin
          mstatus_mie_d  = new_val[MSTATUS_MIE_BIT];
          mstatus_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = new_val & MIE_WRITE_MASK;
        CSR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 1'b0,
                                    new_val[1:0] == MTVEC_MODE_VECTORED};
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & ~XLEN'(3);
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
    if (trap_true) begin
      mepc_d         = bus.pc_in & ~XLEN'(3);
      mcause_d       = trap_cause;
      mtval_d        = '0;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (return_trap) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  assign mcycle_wr_lo   = csr_we & (bus.csr_addr_in == CSR_MCYCLE);
  assign mcycle_wr_hi   = csr_we & (bus.csr_addr_in == CSR_MCYCLEH);
  assign minstret_wr_lo = csr_we & (bus.csr_addr_in == CSR_MINSTRET);
  assign minstret_wr_hi = csr_we & (bus.csr_addr_in == CSR_MINSTRETH);
  assign minstret_inc   = bus.instr_retire_in & ~trap_true;

  csr_counter64 #(.XLEN(XLEN)) u_mcycle (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .inc_en_in  (1'b1),
    .wr_lo_in   (mcycle_wr_lo),
    .wr_hi_in   (mcycle_wr_hi),
    .wr_data_in (new_val),
    .count_out  (mcycle)
  );

  csr_counter64 #(.XLEN(XLEN)) u_minstret (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .inc_en_in  (minstret_inc),
    .wr_lo_in   (minstret_wr_lo),
    .wr_hi_in   (minstret_wr_hi),
    .wr_data_in (new_val),
    .count_out  (minstret)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed walk through the reset, CSR, trap and
// counter scenarios, then randomized traffic compared each cycle against a reference model.
module tb_csr_unit;

  logic clk = 1'b0;
  logic reset_in;
  int   n_checks = 0;
  int   n_errors = 0;

  csr_unit_if #(.XLEN(32)) bus ();

  csr_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk_in   (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: architectural CSR state after the most recent edge.
  bit          model_valid = 1'b0;
  bit          m_mie_en, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hF14, 12'h7C0, 12'h001};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (bus.external_int_in ? 32'h800 : 32'h0) |
           (bus.timer_int_in    ? 32'h080 : 32'h0) |
           (bus.software_int_in ? 32'h008 : 32'h0);
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic [31:0] v, output bit ok);
    ok = 1'b1;
    v  = 32'h0;
    case (a)
      12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie_en ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip();
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      12'hF14: v = 32'h0;
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void m_trap(output bit trap, output logic [31:0] cause,
                                 output logic [31:0] taddr);
    logic [31:0] pend, base, rd;
    bit          ok;
    int          order [3];
    order = '{11, 3, 7};
    trap  = 1'b0;
    cause = 32'h0;
    m_read(bus.csr_addr_in, rd, ok);
    pend = m_mip() & m_mie;
    if (m_mie_en && pend != 0) begin
      foreach (order[i])
        if (!trap && pend[order[i]]) begin
          trap  = 1'b1;
          cause = 32'h8000_0000 | 32'(order[i]);
        end
    end else if (bus.illegal_ins_in || (bus.csr_en_in && !ok)) begin
      trap = 1'b1; cause = 32'd2;
    end else if (bus.ebreak_in) begin
      trap = 1'b1; cause = 32'd3;
    end else if (bus.ecall_in) begin
      trap = 1'b1; cause = 32'd11;
    end
    base  = m_mtvec & ~32'h3;
    taddr = (cause[31] && (m_mtvec & 32'h3) == 32'h1) ? base + (cause & 32'hF) * 4 : base;
    if (reset_in) trap = 1'b0;
  endfunction

  function automatic void m_update();
    bit          trap, ok;
    logic [31:0] cause, taddr, old, src, nv;
    logic [63:0] cyc_n, ins_n;
    if (reset_in) begin
      model_valid = 1'b1;
      m_mie_en = 1'b0; m_mpie = 1'b0;
      m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cycle = 0; m_instret = 0;
      return;
    end
    m_trap(trap, cause, taddr);
    m_read(bus.csr_addr_in, old, ok);
    cyc_n = m_cycle + 1;
    ins_n = m_instret + ((bus.instr_retire_in && !trap) ? 64'd1 : 64'd0);
    src   = bus.csr_imm_in ? {27'b0, bus.src_field_in} : bus.rs1_data_in;
    if (!trap && bus.csr_en_in && ok && bus.csr_op_in != 0 &&
        (bus.csr_op_in == 1 || bus.src_field_in != 0)) begin
      case (bus.csr_op_in)
        2'd1:    nv = src;
        2'd2:    nv = old | src;
        default: nv = old & ~src;
      endcase
      case (bus.csr_addr_in)
        12'h300: begin m_mie_en = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie      = nv & 32'h888;
        12'h305: m_mtvec    = (nv & ~32'h3) | (((nv & 32'h3) == 32'h1) ? 32'h1 : 32'h0);
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        12'hB00: cyc_n = {m_cycle[63:32], nv};
        12'hB80: cyc_n = {nv, m_cycle[31:0]};
        12'hB02: ins_n = {m_instret[63:32], nv};
        12'hB82: ins_n = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      m_mepc   = bus.pc_in & ~32'h3;
      m_mcause = cause;
      m_mtval  = 0;
      m_mpie   = m_mie_en;
      m_mie_en = 1'b0;
    end else if (bus.mret_in) begin
      m_mie_en = m_mpie;
      m_mpie   = 1'b1;
    end
    m_cycle   = cyc_n;
    m_instret = ins_n;
  endfunction

  // Compare all outputs against the model, then advance one clock; starts and ends at negedge.
  task automatic tick();
    bit          exp_trap, exp_ok, exp_ret;
    logic [31:0] exp_rd, exp_cause, exp_addr;
    #1;
    if (model_valid) begin
      m_read(bus.csr_addr_in, exp_rd, exp_ok);
      m_trap(exp_trap, exp_cause, exp_addr);
      exp_ret = bus.mret_in && !exp_trap && !reset_in;
      check("model_rdata", bus.csr_data_out, exp_rd);
      check("model_illegal_csr", bus.illegal_csr_out, bus.csr_en_in && !exp_ok);
      check("model_trap", bus.trap_true_out, exp_trap);
      if (exp_trap) check("model_trap_addr", bus.trap_address_out, exp_addr);
      check("model_return", bus.return_trap_out, exp_ret);
      if (exp_ret) check("model_return_addr", bus.return_address_out, m_mepc);
    end
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.csr_en_in = 0; bus.csr_op_in = 0; bus.csr_imm_in = 0; bus.csr_addr_in = 0;
    bus.src_field_in = 0; bus.rs1_data_in = 0; bus.pc_in = 0; bus.instr_retire_in = 0;
    bus.illegal_ins_in = 0; bus.ecall_in = 0; bus.ebreak_in = 0; bus.mret_in = 0;
    bus.external_int_in = 0; bus.software_int_in = 0; bus.timer_int_in = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic imm, input logic [11:0] a,
                     input logic [4:0] f, input logic [31:0] rs1);
    idle();
    bus.csr_en_in = 1; bus.csr_op_in = op; bus.csr_imm_in = imm; bus.csr_addr_in = a;
    bus.src_field_in = f; bus.rs1_data_in = rs1;
  endtask

  task automatic rd_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle();
    bus.csr_addr_in = a;
    #1;
    check(tag, bus.csr_data_out, exp);
    tick();
  endtask

  initial begin
    idle();
    reset_in = 1'b1;
    @(negedge clk);
    bus.ecall_in = 1; bus.mret_in = 1;
    #1;
    check("rst_trap_forced", bus.trap_true_out, 0);
    check("rst_return_forced", bus.return_trap_out, 0);
    tick();
    tick();
    reset_in = 1'b0;

    rd_expect("rst_mcycle", 12'hB00, 32'h0);
    rd_expect("rst_mstatus", 12'h300, 32'h1800);
    rd_expect("rst_mtvec", 12'h305, 32'h100);
    rd_expect("rst_misa", 12'h301, 32'h4000_0100);

    csr(2'd1, 0, 12'h340, 5'd5, 32'hA5A5_0000);
    #1; check("rw_old", bus.csr_data_out, 32'h0); tick();
    csr(2'd2, 1, 12'h340, 5'h0F, 32'h0);
    #1; check("rs_old", bus.csr_data_out, 32'hA5A5_0000); tick();
    csr(2'd3, 0, 12'h340, 5'd0, 32'hFFFF_FFFF);
    #1; check("rc_old", bus.csr_data_out, 32'hA5A5_000F); tick();
    rd_expect("rc_suppressed", 12'h340, 32'hA5A5_000F);

    csr(2'd2, 1, 12'h300, 5'd8, 32'h0); tick();
    idle(); bus.ecall_in = 1; bus.pc_in = 32'h40;
    #1;
    check("ecall_trap", bus.trap_true_out, 1);
    check("ecall_addr", bus.trap_address_out, 32'h100);
    tick();
    rd_expect("ecall_mepc", 12'h341, 32'h40);
    rd_expect("ecall_mcause", 12'h342, 32'd11);
    rd_expect("ecall_mstatus", 12'h300, 32'h1880);
    idle(); bus.mret_in = 1;
    #1;
    check("mret_accept", bus.return_trap_out, 1);
    check("mret_addr", bus.return_address_out, 32'h40);
    tick();
    rd_expect("mret_mstatus", 12'h300, 32'h1888);

    csr(2'd1, 0, 12'h305, 5'd1, 32'h201); tick();
    csr(2'd1, 0, 12'h304, 5'd1, 32'h888); tick();
    idle(); bus.external_int_in = 1; bus.software_int_in = 1; bus.timer_int_in = 1;
    #1;
    check("irq_all_trap", bus.trap_true_out, 1);
    check("irq_all_addr", bus.trap_address_out, 32'h22C);
    tick();
    rd_expect("irq_all_cause", 12'h342, 32'h8000_000B);
    idle(); bus.mret_in = 1; tick();
    idle(); bus.timer_int_in = 1;
    #1; check("irq_timer_addr", bus.trap_address_out, 32'h21C); tick();

    csr(2'd1, 0, 12'h340, 5'd1, 32'h1234);
    bus.illegal_ins_in = 1; bus.instr_retire_in = 1; bus.pc_in = 32'h80;
    #1;
    check("illegal_trap", bus.trap_true_out, 1);
    check("illegal_addr", bus.trap_address_out, 32'h200);
    tick();
    rd_expect("illegal_no_write", 12'h340, 32'hA5A5_000F);
    rd_expect("illegal_no_retire", 12'hB02, 32'h0);
    idle(); bus.instr_retire_in = 1; tick();
    rd_expect("retire_count", 12'hB02, 32'h1);
    csr(2'd2, 0, 12'h7C0, 5'd0, 32'h0);
    #1;
    check("bad_addr_flag", bus.illegal_csr_out, 1);
    check("bad_addr_rdata", bus.csr_data_out, 32'h0);
    check("bad_addr_trap", bus.trap_true_out, 1);
    tick();

    csr(2'd1, 0, 12'hB00, 5'd1, 32'hFFFF_FFFF); tick();
    rd_expect("cycle_write_wins", 12'hB00, 32'hFFFF_FFFF);
    rd_expect("cycle_carry_hi", 12'hB80, 32'h1);
    csr(2'd1, 0, 12'hB80, 5'd1, 32'hFFFF_FFFF); tick();
    csr(2'd1, 0, 12'hB00, 5'd1, 32'hFFFF_FFFF); tick();
    rd_expect("cycle_max_lo", 12'hB00, 32'hFFFF_FFFF);
    rd_expect("cycle_wrap_hi", 12'hB80, 32'h0);
    rd_expect("cycle_wrap_lo", 12'hB00, 32'h1);

    csr(2'd1, 0, 12'h340, 5'd1, 32'hDEAD_BEEF);
    bus.ecall_in = 1; reset_in = 1'b1;
    #1; check("midrst_trap", bus.trap_true_out, 0);
    tick();
    reset_in = 1'b0;
    rd_expect("midrst_mscratch", 12'h340, 32'h0);

    for (int i = 0; i < 800; i++) begin
      idle();
      reset_in = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.csr_en_in    = 1;
        bus.csr_op_in    = 2'($urandom_range(0, 3));
        bus.csr_imm_in   = 1'($urandom_range(0, 1));
        bus.csr_addr_in  = addr_pool[$urandom_range(0, 15)];
        bus.src_field_in = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        bus.rs1_data_in  = $urandom();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.mret_in = 1;
      end
      bus.pc_in           = $urandom();
      bus.instr_retire_in = 1'($urandom_range(0, 1));
      bus.illegal_ins_in  = ($urandom_range(0, 15) == 0);
      bus.ecall_in        = ($urandom_range(0, 11) == 0);
      bus.ebreak_in       = ($urandom_range(0, 11) == 0);
      bus.external_int_in = ($urandom_range(0, 3) == 0);
      bus.software_int_in = ($urandom_range(0, 3) == 0);
      bus.timer_int_in    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
